// File: rtl/invader_hit_detect.sv
// rtl/invader_hit_detect.sv - per-frame bullet vs invader-grid collision scan with kill event port
module invader_hit_detect #(
  parameter int cols_p      = 8,
  parameter int rows_p      = 4,
  parameter int enemy_w_p   = 16,
  parameter int enemy_h_p   = 12,
  parameter int spacing_x_p = 24,
  parameter int spacing_y_p = 20,
  parameter int score_w_p   = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  frame_i,
  input  logic                                  new_wave_i,
  input  logic [9:0]                            grid_left_i,
  input  logic [9:0]                            grid_top_i,
  input  logic                                  bullet_active_i,
  input  logic [9:0]                            bullet_left_i,
  input  logic [9:0]                            bullet_right_i,
  input  logic [9:0]                            bullet_top_i,
  input  logic [9:0]                            bullet_bot_i,
  output logic                                  enemy_hit_o,
  output logic [cols_p*rows_p-1:0]              alive_o,
  output logic [$clog2(cols_p*rows_p+1)-1:0]    alive_count_o,
  output logic [score_w_p-1:0]                  score_o,
  output logic                                  wave_clear_o,
  output logic [$clog2(cols_p*rows_p)-1:0]      hit_index_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic                                  busy_o
);

  localparam int n_c   = cols_p * rows_p;
  localparam int cnt_w = $clog2(n_c + 1);
  localparam int idx_w = $clog2(n_c);
  localparam int col_w = (cols_p > 1) ? $clog2(cols_p) : 1;
  localparam int row_w = (rows_p > 1) ? $clog2(rows_p) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t              state, state_nx;
  logic [col_w-1:0]    col_q;
  logic [row_w-1:0]    row_q;
  logic                go_q;
  logic [9:0]          b_left_q, b_right_q, b_top_q, b_bot_q;
  logic [9:0]          org_left_q, org_top_q;
  logic [n_c-1:0]      alive_q;
  logic [cnt_w-1:0]    count_q;
  logic [score_w_p-1:0] score_q;
  logic [idx_w-1:0]    hit_idx_q;
  logic                enemy_hit_q;
  logic                wave_clear_q;

  logic [10:0]         e_left, e_right, e_top, e_bot;
  logic                overlap, last_idx, start, kill;
  logic [idx_w-1:0]    cur_idx;
  logic [score_w_p:0]  score_sum;

  always_comb begin
    e_left    = {1'b0, org_left_q} + 11'(col_q) * 11'(spacing_x_p);
    e_right   = e_left + 11'(enemy_w_p - 1);
    e_top     = {1'b0, org_top_q} + 11'(row_q) * 11'(spacing_y_p);
    e_bot     = e_top + 11'(enemy_h_p - 1);
    overlap   = ({1'b0, b_left_q} <= e_right) && ({1'b0, b_right_q} >= e_left) &&
                ({1'b0, b_top_q} <= e_bot) && ({1'b0, b_bot_q} >= e_top);
    cur_idx   = idx_w'(row_q) * idx_w'(cols_p) + idx_w'(col_q);
    last_idx  = (col_q == col_w'(cols_p - 1)) && (row_q == row_w'(rows_p - 1));
    start     = (state == IDLE) && frame_i && bullet_active_i && (count_q != '0);
    // the first SCAN cycle only arms the compare; enemies are evaluated from the next cycle on
    kill      = (state == SCAN) && go_q && overlap && alive_q[cur_idx];
    score_sum = {1'b0, score_q} + (score_w_p + 1)'(10 * (rows_p - int'(row_q)));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (new_wave_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = SCAN;
        SCAN:    if (kill) state_nx = REPORT;
                 else if (go_q && last_idx) state_nx = IDLE;
        REPORT:  if (ready_i) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_o = (state == REPORT);
    busy_o  = (state != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_q        <= '0;
      row_q        <= '0;
      go_q         <= 1'b0;
      b_left_q     <= '0;
      b_right_q    <= '0;
      b_top_q      <= '0;
      b_bot_q      <= '0;
      org_left_q   <= '0;
      org_top_q    <= '0;
      alive_q      <= '1;
      count_q      <= cnt_w'(n_c);
      score_q      <= '0;
      hit_idx_q    <= '0;
      enemy_hit_q  <= 1'b0;
      wave_clear_q <= 1'b0;
    end else begin
      enemy_hit_q <= kill && !new_wave_i;
      if (start && !new_wave_i) begin
        b_left_q   <= bullet_left_i;
        b_right_q  <= bullet_right_i;
        b_top_q    <= bullet_top_i;
        b_bot_q    <= bullet_bot_i;
        org_left_q <= grid_left_i;
        org_top_q  <= grid_top_i;
        col_q      <= '0;
        row_q      <= '0;
        go_q       <= 1'b0;
      end else if (state == SCAN) begin
        if (!go_q) begin
          go_q <= 1'b1;
        end else if (!kill) begin
          if (col_q == col_w'(cols_p - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
      end
      if (new_wave_i) begin
        alive_q      <= '1;
        count_q      <= cnt_w'(n_c);
        wave_clear_q <= 1'b0;
      end else if (kill) begin
        alive_q[cur_idx] <= 1'b0;
        count_q          <= count_q - 1'b1;
        wave_clear_q     <= (count_q == cnt_w'(1));
        score_q          <= score_sum[score_w_p] ? '1 : score_sum[score_w_p-1:0];
        hit_idx_q        <= cur_idx;
      end
    end
  end

  assign enemy_hit_o   = enemy_hit_q;
  assign alive_o       = alive_q;
  assign alive_count_o = count_q;
  assign score_o       = score_q;
  assign wave_clear_o  = wave_clear_q;
  assign hit_index_o   = hit_idx_q;

endmodule

// File: tb/tb_invader_hit_detect.sv
// tb/tb_invader_hit_detect.sv - directed self-checking bench for invader_hit_detect
module tb_invader_hit_detect;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        frame_i, new_wave_i, bullet_active_i, ready_i;
  logic [9:0]  grid_left_i, grid_top_i;
  logic [9:0]  bullet_left_i, bullet_right_i, bullet_top_i, bullet_bot_i;
  logic        enemy_hit_o, wave_clear_o, valid_o, busy_o;
  logic [31:0] alive_o;
  logic [5:0]  alive_count_o;
  logic [15:0] score_o;
  logic [4:0]  hit_index_o;

  int tests = 0;
  int fails = 0;

  invader_hit_detect dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_i(frame_i), .new_wave_i(new_wave_i),
    .grid_left_i(grid_left_i), .grid_top_i(grid_top_i), .bullet_active_i(bullet_active_i),
    .bullet_left_i(bullet_left_i), .bullet_right_i(bullet_right_i),
    .bullet_top_i(bullet_top_i), .bullet_bot_i(bullet_bot_i),
    .enemy_hit_o(enemy_hit_o), .alive_o(alive_o), .alive_count_o(alive_count_o),
    .score_o(score_o), .wave_clear_o(wave_clear_o), .hit_index_o(hit_index_o),
    .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_box(input int l, input int r, input int t, input int b);
    bullet_left_i  = 10'(l);
    bullet_right_i = 10'(r);
    bullet_top_i   = 10'(t);
    bullet_bot_i   = 10'(b);
  endtask

  task automatic pulse_new_wave;
    new_wave_i = 1'b1;
    tick;
    new_wave_i = 1'b0;
  endtask

  // hit_at counts edges after the frame edge; idx is -1 when nothing was killed
  task automatic run_frame(input int l, input int r, input int t, input int b,
                           output int hit_at, output int pulses, output int idx);
    set_box(l, r, t, b);
    frame_i = 1'b1;
    tick;
    frame_i = 1'b0;
    hit_at = -1;
    pulses = 0;
    idx    = -1;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (enemy_hit_o) begin
        pulses++;
        if (hit_at < 0) begin
          hit_at = n;
          idx    = int'(hit_index_o);
        end
      end
      if (!busy_o) break;
    end
    check("scan_done", busy_o, 0);
  endtask

  int hit_at, pulses, idx;
  int bl[6] = '{116, 115, 98, 100, 105, 105};
  int br[6] = '{117, 115, 99, 100, 105, 105};
  int bt[6] = '{55, 55, 55, 55, 62, 61};
  int bb[6] = '{56, 55, 56, 55, 63, 61};
  int bh[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    reset_i = 1'b1; frame_i = 1'b0; new_wave_i = 1'b0; bullet_active_i = 1'b1;
    ready_i = 1'b1; grid_left_i = 10'd100; grid_top_i = 10'd50;
    set_box(0, 0, 0, 0);
    tick; tick;
    reset_i = 1'b0;
    check("rst_alive", alive_o, 32'hffff_ffff);
    check("rst_count", alive_count_o, 32);
    check("rst_score", score_o, 0);
    check("rst_hit_index", hit_index_o, 0);
    check("rst_enemy_hit", enemy_hit_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wave_clear", wave_clear_o, 0);

    run_frame(110, 111, 55, 62, hit_at, pulses, idx);
    check("t1_hit_at", hit_at, 2);
    check("t1_pulses", pulses, 1);
    check("t1_idx", idx, 0);
    check("t1_score", score_o, 40);
    check("t1_count", alive_count_o, 31);
    check("t1_alive0", alive_o[0], 0);

    run_frame(110, 111, 55, 62, hit_at, pulses, idx);
    check("t2_pulses", pulses, 0);
    check("t2_score", score_o, 40);
    check("t2_count", alive_count_o, 31);

    run_frame(135, 150, 55, 56, hit_at, pulses, idx);
    check("t3_hit_at", hit_at, 3);
    check("t3_idx", idx, 1);
    check("t3_score", score_o, 80);
    check("t3_count", alive_count_o, 30);
    check("t3_alive1", alive_o[1], 0);
    check("t3_alive2", alive_o[2], 1);

    pulse_new_wave;
    check("nw_count", alive_count_o, 32);
    check("nw_score_kept", score_o, 80);
    for (int k = 0; k < 6; k++) begin
      pulse_new_wave;
      run_frame(bl[k], br[k], bt[k], bb[k], hit_at, pulses, idx);
      check("bnd_pulses", pulses, bh[k]);
      check("bnd_idx", idx, (bh[k] != 0) ? 0 : -1);
    end
    check("bnd_score", score_o, 200);

    pulse_new_wave;
    ready_i = 1'b0;
    set_box(100, 100, 50, 50);
    frame_i = 1'b1;
    tick;
    frame_i = 1'b0;
    tick; tick;
    check("bp_valid_rise", valid_o, 1);
    check("bp_hit_rise", enemy_hit_o, 1);
    check("bp_index", hit_index_o, 0);
    tick; tick; tick;
    check("bp_valid_hold", valid_o, 1);
    check("bp_hit_once", enemy_hit_o, 0);
    check("bp_index_hold", hit_index_o, 0);
    set_box(124, 124, 50, 50);
    frame_i = 1'b1;
    tick;
    frame_i = 1'b0;
    check("bp_drop_busy", busy_o, 1);
    check("bp_drop_valid", valid_o, 1);
    ready_i = 1'b1;
    tick;
    check("bp_idle_busy", busy_o, 0);
    check("bp_idle_valid", valid_o, 0);
    tick; tick; tick;
    check("bp_no_rescan", busy_o, 0);
    check("bp_alive1", alive_o[1], 1);
    check("bp_count", alive_count_o, 31);
    check("bp_score", score_o, 240);

    set_box(1000, 1000, 1000, 1000);
    frame_i = 1'b1;
    tick;
    frame_i = 1'b0;
    tick; tick; tick; tick;
    check("ms_busy", busy_o, 1);
    reset_i = 1'b1;
    #1;
    check("ms_busy_rst", busy_o, 0);
    check("ms_alive", alive_o, 32'hffff_ffff);
    check("ms_count", alive_count_o, 32);
    check("ms_score", score_o, 0);
    check("ms_valid", valid_o, 0);
    check("ms_hit_index", hit_index_o, 0);
    tick;
    reset_i = 1'b0;

    for (int i = 0; i < 32; i++) begin
      run_frame(100 + 24 * (i % 8), 100 + 24 * (i % 8), 50 + 20 * (i / 8), 50 + 20 * (i / 8),
                hit_at, pulses, idx);
      check("kill_idx", idx, i);
    end
    check("all_count", alive_count_o, 0);
    check("all_wave_clear", wave_clear_o, 1);
    check("all_alive", alive_o, 0);
    check("all_score", score_o, 800);
    set_box(100, 100, 50, 50);
    frame_i = 1'b1;
    tick;
    frame_i = 1'b0;
    check("clear_no_scan", busy_o, 0);
    pulse_new_wave;
    check("wave_alive", alive_o, 32'hffff_ffff);
    check("wave_count", alive_count_o, 32);
    check("wave_score", score_o, 800);
    check("wave_clear_low", wave_clear_o, 0);

    new_wave_i = 1'b1;
    frame_i = 1'b1;
    tick;
    new_wave_i = 1'b0;
    frame_i = 1'b0;
    check("co_busy", busy_o, 0);
    tick; tick; tick;
    check("co_count", alive_count_o, 32);
    check("co_hit", enemy_hit_o, 0);
    check("co_score", score_o, 800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
